hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//   Parametrised successor to the forwarding-only hazard unit of the 5-stage RV32I pipeline.
//   - Adds load-use stalling, taken-branch flushing and whole-pipe freeze on data-memory wait.
//   - Adds saturating stall/flush performance counters.
//   - Sits beside the F/D/E/M/W stages; drives the stall/flush pins of every pipeline register and the E-stage forward muxes.
// PARAMETERS
//   REG_ADDR_W     5   register index width (x0 is hard-wired zero)
//   LU_STALL_CYC   1   F/D stall cycles per load-use hazard (1..7)
//   CNT_W          32  width of the performance counters
// PORTS
//   clk            in   1             rising-edge clock
//   rst            in   1             synchronous, active-high reset
//   rs1_d, rs2_d   in   REG_ADDR_W    source registers of the instruction in D
//   rs1_e, rs2_e   in   REG_ADDR_W    source registers of the instruction in E
//   rd_e           in   REG_ADDR_W    destination register in E
//   result_src_e   in   1             1 = instruction in E is a load
//   rd_m           in   REG_ADDR_W    destination register in M
//   reg_write_m    in   1             M writes the register file
//   rd_w           in   REG_ADDR_W    destination register in W
//   reg_write_w    in   1             W writes the register file
//   pc_src_e       in   1             taken branch/jump resolved in E
//   mem_busy_m     in   1             data memory not ready; M must hold
//   forward_a_e    out  2             00 RD1_E, 10 ALU_Result_M, 01 ResultW
//   forward_b_e    out  2             same encoding, for operand B
//   stall_f        out  1             hold PC
//   stall_d        out  1             hold the F/D register
//   stall_e        out  1             hold the D/E register
//   stall_m        out  1             hold the E/M and M/W registers
//   flush_d        out  1             clear the F/D register to NOP
//   flush_e        out  1             clear the D/E register to a bubble
//   stall_cnt      out  CNT_W         cycles with stall_f=1, saturating
//   flush_cnt      out  CNT_W         taken-branch flush events, saturating
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//     - FSM goes to RUN; counter lu_cnt, stall_cnt and flush_cnt go to 0.
//     - Combinational outputs are forced to 0 while rst=1.
//   Forwarding (combinational; evaluated in every state):
//     - Operand A: 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
//     - Otherwise 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
//     - Otherwise 00. M has priority over W. Operand B is identical with rs2_e.
//   Load-use detect:
//     - lu = result_src_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
//   FSM states: RUN, LU_STALL, MEM_FREEZE. Priority order is mem_busy_m > pc_src_e > lu.
//   RUN:
//     - mem_busy_m -> MEM_FREEZE. Same cycle: stall_f/d/e/m=1, no flush.
//     - else pc_src_e -> flush_d=1, flush_e=1, flush_cnt+1, stay in RUN.
//       A load-use in the same cycle is squashed: the D instruction is on the wrong path.
//     - else lu -> stall_f=stall_d=1 and flush_e=1 this cycle.
//       If LU_STALL_CYC>1, go to LU_STALL with lu_cnt=LU_STALL_CYC-1; otherwise stay in RUN.
//   LU_STALL:
//     - Each cycle: stall_f=stall_d=1, flush_e=1, lu_cnt-1.
//     - When lu_cnt reaches 1, return to RUN at the next edge.
//     - mem_busy_m takes priority: go to MEM_FREEZE and keep lu_cnt; resume LU_STALL on exit.
//   MEM_FREEZE:
//     - stall_f/d/e/m=1 while mem_busy_m=1; all flushes held at 0.
//     - On mem_busy_m=0: same cycle outputs are as in RUN; next state is RUN, or LU_STALL if lu_cnt!=0.
//   Latency:
//     - Stall/flush outputs are combinational from the current inputs and state, so they take effect at the next edge.
//     - Counters update at that same edge.
//   Counters:
//     - stall_cnt +1 on every cycle with stall_f=1.
//     - flush_cnt +1 on every cycle with flush_d=1.
//     - Both hold at 2^CNT_W-1 (no wrap).
//   Reset mid-operation: abandons LU_STALL/MEM_FREEZE immediately; no residual stall after rst falls.
// STRUCTURE
//   Shared package (pipe_pkg): FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; FSM state enum; REG_ADDR_W default.
//   One natural sub-module: hazard_fwd_sel. It is combinational, one instance per operand, and computes the 2-bit select from rs, rd_m/w and reg_write_m/w.
//   FSM, lu_cnt and counters stay in this module.
// TESTING
//   1. rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=10 (M wins).
//      rd_m=0 instead -> forward_a_e=01.
//   2. result_src_e=1, rd_e=7, rs2_d=7, LU_STALL_CYC=3 -> stall_f=stall_d=flush_e=1 for exactly 3 cycles; stall_cnt=3.
//   3. pc_src_e=1 together with a load-use match -> flush_d=flush_e=1, stall_f=0; flush_cnt=1; no LU_STALL entered.
//   4. mem_busy_m=1 for 4 cycles during LU_STALL (lu_cnt=2) -> all four stalls high for 4 cycles, flushes 0.
//      Afterwards, exactly 2 more load-use stall cycles follow.
//   5. CNT_W=4, 20 consecutive stall cycles -> stall_cnt saturates at 15.
//   6. rst asserted in MEM_FREEZE -> next cycle all outputs 0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-mux encodings, hazard FSM states, default register index width.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_STALL   = 2'd1,
        MEM_FREEZE = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward-select for the E stage; M result has priority over W, x0 is never forwarded.
module hazard_fwd_sel
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic [1:0]            fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: operand forwarding, load-use stall, branch flush, memory-wait freeze
// and saturating stall/flush performance counters.
module hazard_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  result_src_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    input  logic                  pc_src_e,
    input  logic                  mem_busy_m,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYC - 1);

    hz_state_t  state, state_nxt;
    logic [2:0] lu_cnt, lu_cnt_nxt;
    logic [1:0] fwd_a, fwd_b;
    logic       lu;

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_a)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_b)
    );

    assign lu = result_src_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        forward_a_e = rst ? FWD_REG : fwd_a;
        forward_b_e = rst ? FWD_REG : fwd_b;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        state_nxt   = state;
        lu_cnt_nxt  = lu_cnt;
        if (!rst) begin
            unique case (state)
                RUN, MEM_FREEZE: begin
                    if (mem_busy_m) begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                        state_nxt = MEM_FREEZE;
                    end else begin
                        state_nxt = RUN;
                        if (pc_src_e) begin
                            flush_d = 1'b1;
                            flush_e = 1'b1;
                        end else if (lu) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            flush_e = 1'b1;
                            if (LU_INIT != '0) begin
                                state_nxt  = LU_STALL;
                                lu_cnt_nxt = LU_INIT;
                            end
                        end
                        // Freeze exit behaves like RUN this cycle, but an interrupted load-use stall resumes.
                        if (state == MEM_FREEZE && lu_cnt != '0) begin
                            state_nxt  = LU_STALL;
                            lu_cnt_nxt = lu_cnt;
                        end
                    end
                end
                LU_STALL: begin
                    if (mem_busy_m) begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                        state_nxt = MEM_FREEZE;
                    end else begin
                        stall_f    = 1'b1;
                        stall_d    = 1'b1;
                        flush_e    = 1'b1;
                        lu_cnt_nxt = lu_cnt - 3'd1;
                        if (lu_cnt <= 3'd1) begin
                            state_nxt = RUN;
                        end
                    end
                end
                default: begin
                    state_nxt  = RUN;
                    lu_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            lu_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
            if (stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_d && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit (LU_STALL_CYC=3, CNT_W=4).
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       result_src_e, reg_write_m, reg_write_w, pc_src_e, mem_busy_m;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [3:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_ADDR_W   (5),
        .LU_STALL_CYC (3),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .result_src_e (result_src_e),
        .rd_m         (rd_m),
        .reg_write_m  (reg_write_m),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
        .pc_src_e     (pc_src_e),
        .mem_busy_m   (mem_busy_m),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        result_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        pc_src_e = 1'b0; mem_busy_m = 1'b0;
    endtask

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    function automatic logic [31:0] ctl();
        return 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e});
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        // combinational outputs forced low while reset is held
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; mem_busy_m = 1'b1;
        #1;
        check("rst_fwd_a", 32'(forward_a_e), 32'h0);
        check("rst_ctl", ctl(), 32'h00);
        tick();
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        clear_inputs();
        rst = 1'b0;
        #1;
        check("idle_ctl", ctl(), 32'h00);

        // forwarding priority and x0 handling
        rs1_e = 5'd5; rs2_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
        #1;
        check("fwd_a_mem_wins", 32'(forward_a_e), 32'h2);
        check("fwd_b_mem_wins", 32'(forward_b_e), 32'h2);
        rd_m = 5'd0;
        #1;
        check("fwd_a_wb", 32'(forward_a_e), 32'h1);
        reg_write_w = 1'b0;
        #1;
        check("fwd_a_none", 32'(forward_a_e), 32'h0);
        rs1_e = 5'd0; rs2_e = 5'd9; reg_write_m = 1'b1; reg_write_w = 1'b1; rd_w = 5'd9;
        #1;
        check("fwd_a_x0", 32'(forward_a_e), 32'h0);
        check("fwd_b_wb", 32'(forward_b_e), 32'h1);
        clear_inputs();

        // load writing x0 is not a hazard
        result_src_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
        #1;
        check("lu_x0_ctl", ctl(), 32'h00);
        clear_inputs();

        // load-use: 3 stall cycles
        result_src_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        check("lu_c1_ctl", ctl(), 32'h31);
        tick();
        clear_inputs();
        #1;
        check("lu_c2_ctl", ctl(), 32'h31);
        tick();
        check("lu_c3_ctl", ctl(), 32'h31);
        tick();
        check("lu_done_ctl", ctl(), 32'h00);
        check("lu_stall_cnt", 32'(stall_cnt), 32'h3);

        // branch taken squashes a simultaneous load-use
        pc_src_e = 1'b1; result_src_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
        #1;
        check("br_ctl", ctl(), 32'h03);
        tick();
        clear_inputs();
        #1;
        check("br_no_lu_ctl", ctl(), 32'h00);
        check("br_flush_cnt", 32'(flush_cnt), 32'h1);
        check("br_stall_cnt", 32'(stall_cnt), 32'h3);

        // freeze during LU_STALL with two stall cycles left
        result_src_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
        #1;
        check("lf_start_ctl", ctl(), 32'h31);
        tick();
        clear_inputs();
        mem_busy_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("lf_freeze%0d_ctl", i), ctl(), 32'h3C);
            tick();
        end
        mem_busy_m = 1'b0;
        #1;
        check("lf_exit_ctl", ctl(), 32'h00);
        tick();
        check("lf_resume1_ctl", ctl(), 32'h31);
        tick();
        check("lf_resume2_ctl", ctl(), 32'h31);
        tick();
        check("lf_done_ctl", ctl(), 32'h00);
        check("lf_stall_cnt", 32'(stall_cnt), 32'hA);

        // saturation of the 4-bit stall counter
        mem_busy_m = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_ctl", ctl(), 32'h3C);
        check("sat_stall_cnt", 32'(stall_cnt), 32'hF);
        check("sat_flush_cnt", 32'(flush_cnt), 32'h1);

        // reset in MEM_FREEZE
        rst = 1'b1;
        #1;
        check("rstf_ctl", ctl(), 32'h00);
        tick();
        rst = 1'b0;
        mem_busy_m = 1'b0;
        #1;
        check("rstf_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rstf_flush_cnt", 32'(flush_cnt), 32'h0);
        check("rstf_ctl_after", ctl(), 32'h00);
        tick();
        check("rstf_no_residual", ctl(), 32'h00);
        check("rstf_stall_cnt2", 32'(stall_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
